game_round_controller: RTL
==========================

Name: game_round_controller

Overview:
Sequences one round of the card game. Arbitrates a single shared card source between the player and master hand accumulators, and issues each hand's per-card ready pulse. Handles the player's hit/stand decisions and runs the master's draw loop until the master accumulator reports finish. Compares the 5-bit totals and publishes the round result. Sits between the card generator and the player/master accumulator blocks.

Parameters:
INIT_CARDS, 2, cards dealt to each hand at round start (1..4)
MAX_CARDS, 8, per-hand card cap (1..15); reaching it forces end of that hand's turn
TIMEOUT_CYCLES, 1024, idle cycles in PLAYER_TURN before auto-stand (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
new_Game_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a round from IDLE or DONE
hit  in  1  pulse; player requests a card
stand  in  1  pulse; player ends turn
card_valid  in  1  card source has a card on card_value
card_value  in  4  card value 1..11
totalValuePlayer  in  5  player accumulator total
totalValueMaster  in  5  master accumulator total
finishMaster  in  1  master accumulator finished
card_req  out  1  request to card source
cardValue  out  4  card forwarded to the hands
cardReadyPlayer  out  1  one-cycle load strobe to the player accumulator
cardReadyMaster  out  1  one-cycle load strobe to the master accumulator
round_clear  out  1  one-cycle active-high clear to both accumulators
busy  out  1  high in every state except IDLE and DONE
result_valid  out  1  high in DONE
result  out  2  00 none, 01 player wins, 10 master wins, 11 push

Behaviour:
- Reset is asynchronous and active-low. While new_Game_n=0: state=IDLE; all outputs 0; card counters and the target flag cleared. Reset mid-round aborts the round with no result.
- States: IDLE, CLEAR, INIT_REQ, INIT_LOAD, INIT_SETTLE, PLAYER_TURN, P_REQ, P_LOAD, P_SETTLE, M_REQ, M_LOAD, M_SETTLE, COMPARE, DONE.
- IDLE/DONE + start -> CLEAR. In CLEAR, round_clear=1 for exactly 1 cycle. Counters and result are zeroed. Next state is INIT_REQ. start is ignored in all other states.
- Card handshake (all *_REQ states): card_req=1 until a cycle where card_valid=1. In that cycle card_value is captured into cardValue and the FSM moves to *_LOAD.
- *_LOAD: strobe to the target hand for exactly 1 cycle; cardValue stays stable. *_SETTLE: one cycle with no strobe, which lets the total update. The next decision uses the settled total.
- Minimum card latency: 3 cycles from card_req assertion to the settle cycle when card_valid is already high.
- Initial deal alternates P,M,P,M… until each hand holds INIT_CARDS cards. Then -> PLAYER_TURN.
- PLAYER_TURN:
  - totalValuePlayer>=21 or player count==MAX_CARDS -> M_REQ, or COMPARE if the player is bust (>21).
  - stand -> master phase. If hit and stand are asserted together, stand wins.
  - hit -> P_REQ. After P_SETTLE, return to PLAYER_TURN.
  - hit/stand outside PLAYER_TURN are ignored (not queued).
- Master phase: if finishMaster=1 or master count==MAX_CARDS -> COMPARE. Otherwise M_REQ -> M_LOAD -> M_SETTLE -> re-check.
- COMPARE (1 cycle), first matching rule applies:
  - player>21 -> 10
  - master>21 -> 01
  - player>master -> 01
  - master>player -> 10
  - equal -> 11
- Then DONE: result holds with result_valid=1 until start or reset.
- Card counters are 4-bit and saturate at MAX_CARDS; they never wrap.

Optional Feature:
PLAYER_TIMEOUT_EN. Defined: a 16-bit idle counter runs in PLAYER_TURN and resets on entry and on any hit/stand. When it reaches TIMEOUT_CYCLES, the controller acts as an implicit stand. Undefined: no counter; PLAYER_TURN waits indefinitely.

Decomposition:
- Shared package game_pkg holds:
  - state enum
  - result codes RES_NONE/RES_PLAYER/RES_MASTER/RES_PUSH
  - BLACKJACK=21
  - card and total widths (4, 5)
- One natural sub-module, card_fetch: the REQ/LOAD/SETTLE handshake sequencer. It takes target select and go, and returns done. It is shared by the init, player and master phases.

Test Plan:
- Reset mid-round: assert new_Game_n=0 during P_REQ -> all outputs 0 immediately; state IDLE; no strobes after release.
- Initial deal: start with cards 10,9,5,7 -> round_clear pulse; strobes P,M,P,M with cardValue 10,9,5,7; then PLAYER_TURN with totals P=15, M=16.
- Player bust: hit then card 9 (P=15->24) -> no master cards; result=10, result_valid=1.
- Master loop: stand at P=18, M=16; source gives 3 then finishMaster -> one cardReadyMaster; M=19; result=10 (master wins).
- Push and simultaneous inputs: hit+stand same cycle with P=20; master reaches 20 -> no player card; result=11.
- Handshake stall: card_valid held low 5 cycles -> card_req stays high, no strobe; strobe follows 1 cycle after card_valid. With PLAYER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no hit/stand -> auto-stand after 16 cycles.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the card-game round controller and its card fetch sequencer.
package game_pkg;

  localparam int CARD_W  = 4;
  localparam int TOTAL_W = 5;

  localparam logic [TOTAL_W-1:0] BLACKJACK = 5'd21;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_MASTER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  typedef enum logic [3:0] {
    IDLE, CLEAR, INIT_REQ, INIT_LOAD, INIT_SETTLE, PLAYER_TURN,
    P_REQ, P_LOAD, P_SETTLE, M_REQ, M_LOAD, M_SETTLE, COMPARE, DONE
  } state_t;

  // Bust checks come before the plain comparison, so a busted player loses even if the master also busts.
  function automatic logic [1:0] judge(input logic [TOTAL_W-1:0] p, input logic [TOTAL_W-1:0] m);
    if (p > BLACKJACK)      judge = RES_MASTER;
    else if (m > BLACKJACK) judge = RES_PLAYER;
    else if (p > m)         judge = RES_PLAYER;
    else if (m > p)         judge = RES_MASTER;
    else                    judge = RES_PUSH;
  endfunction

endpackage

// File: rtl/game_round_controller_card_fetch.sv
// card_fetch: request/load/settle handshake with the shared card source; holds the forwarded card
// and steers the one-cycle load strobe to the selected hand.
module card_fetch
  import game_pkg::*;
(
  input  logic              clock,
  input  logic              new_Game_n,
  input  logic              clear_i,
  input  logic              req_i,
  input  logic              load_i,
  input  logic              settle_i,
  input  logic              tgt_master_i,
  input  logic              card_valid_i,
  input  logic [CARD_W-1:0] card_value_i,
  output logic              card_req_o,
  output logic              got_o,
  output logic              ready_p_o,
  output logic              ready_m_o,
  output logic              done_o,
  output logic [CARD_W-1:0] card_o
);

  logic [CARD_W-1:0] card_q, card_d;

  assign card_req_o = req_i;
  assign got_o      = req_i & card_valid_i;
  assign ready_p_o  = load_i & ~tgt_master_i;
  assign ready_m_o  = load_i & tgt_master_i;
  assign done_o     = settle_i;
  assign card_o     = card_q;

  always_comb begin
    card_d = card_q;
    if (clear_i)    card_d = '0;
    else if (got_o) card_d = card_value_i;
  end

  always_ff @(posedge clock or negedge new_Game_n) begin
    if (!new_Game_n) card_q <= '0;
    else             card_q <= card_d;
  end

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer: initial deal, player hit/stand, master draw loop, compare and result hold.
// Optional PLAYER_TIMEOUT_EN adds an idle auto-stand timer in PLAYER_TURN.
module game_round_controller
  import game_pkg::*;
#(
  parameter int INIT_CARDS     = 2,
  parameter int MAX_CARDS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               new_Game_n,
  input  logic               start,
  input  logic               hit,
  input  logic               stand,
  input  logic               card_valid,
  input  logic [CARD_W-1:0]  card_value,
  input  logic [TOTAL_W-1:0] totalValuePlayer,
  input  logic [TOTAL_W-1:0] totalValueMaster,
  input  logic               finishMaster,
  output logic               card_req,
  output logic [CARD_W-1:0]  cardValue,
  output logic               cardReadyPlayer,
  output logic               cardReadyMaster,
  output logic               round_clear,
  output logic               busy,
  output logic               result_valid,
  output logic [1:0]         result
);

  // state        | meaning
  // CLEAR        | one-cycle accumulator clear, counters zeroed
  // *_REQ/LOAD/SETTLE | card handshake, strobe, total settle (INIT, P, M)
  // PLAYER_TURN  | waits for hit/stand; COMPARE for 1 cycle; DONE holds result

  localparam logic [3:0] MAX_C  = 4'(MAX_CARDS);
  localparam logic [3:0] INIT_C = (INIT_CARDS > MAX_CARDS) ? 4'(MAX_CARDS) : 4'(INIT_CARDS);

  state_t     state_q, state_d, master_next;
  logic [3:0] p_cnt_q, p_cnt_d, m_cnt_q, m_cnt_d;
  logic       tgt_q, tgt_d;
  logic [1:0] result_q, result_d;
  logic       in_req, in_load, in_settle, tgt_master, got, done;
  logic       p_full, m_full, tmo, stand_eff;

`ifdef PLAYER_TIMEOUT_EN
  localparam logic [15:0] TMO_C = 16'(TIMEOUT_CYCLES);
  logic [15:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (state_q != PLAYER_TURN || hit || stand) idle_d = TMO_C;
    else if (idle_q != '0)                      idle_d = idle_q - 16'd1;
  end

  always_ff @(posedge clock or negedge new_Game_n) begin
    if (!new_Game_n) idle_q <= TMO_C;
    else             idle_q <= idle_d;
  end

  assign tmo = (state_q == PLAYER_TURN) && (idle_q == '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  assign in_req     = state_q inside {INIT_REQ, P_REQ, M_REQ};
  assign in_load    = state_q inside {INIT_LOAD, P_LOAD, M_LOAD};
  assign in_settle  = state_q inside {INIT_SETTLE, P_SETTLE, M_SETTLE};
  assign tgt_master = (state_q inside {M_REQ, M_LOAD, M_SETTLE}) ||
                      ((state_q inside {INIT_REQ, INIT_LOAD, INIT_SETTLE}) && tgt_q);
  assign p_full     = (p_cnt_q == MAX_C);
  assign m_full     = (m_cnt_q == MAX_C);
  assign stand_eff  = stand | tmo;
  assign master_next = (finishMaster || m_full) ? COMPARE : M_REQ;

  card_fetch u_fetch (
    .clock        (clock),
    .new_Game_n   (new_Game_n),
    .clear_i      (state_q == CLEAR),
    .req_i        (in_req),
    .load_i       (in_load),
    .settle_i     (in_settle),
    .tgt_master_i (tgt_master),
    .card_valid_i (card_valid),
    .card_value_i (card_value),
    .card_req_o   (card_req),
    .got_o        (got),
    .ready_p_o    (cardReadyPlayer),
    .ready_m_o    (cardReadyMaster),
    .done_o       (done),
    .card_o       (cardValue)
  );

  always_comb begin
    state_d  = state_q;
    p_cnt_d  = p_cnt_q;
    m_cnt_d  = m_cnt_q;
    tgt_d    = tgt_q;
    result_d = result_q;
    if (in_load && !tgt_master && !p_full) p_cnt_d = p_cnt_q + 4'd1;
    if (in_load && tgt_master && !m_full)  m_cnt_d = m_cnt_q + 4'd1;
    case (state_q)
      IDLE, DONE: if (start) state_d = CLEAR;
      CLEAR: begin
        p_cnt_d  = '0;
        m_cnt_d  = '0;
        tgt_d    = 1'b0;
        result_d = RES_NONE;
        state_d  = INIT_REQ;
      end
      INIT_REQ:  if (got) state_d = INIT_LOAD;
      INIT_LOAD: state_d = INIT_SETTLE;
      INIT_SETTLE: if (done) begin
        if (p_cnt_q >= INIT_C && m_cnt_q >= INIT_C) state_d = PLAYER_TURN;
        else begin
          tgt_d   = ~tgt_q;
          state_d = INIT_REQ;
        end
      end
      // Stand outranks hit, so a simultaneous hit+stand never draws a card.
      PLAYER_TURN: begin
        if (totalValuePlayer > BLACKJACK) state_d = COMPARE;
        else if (totalValuePlayer == BLACKJACK || p_full || stand_eff) state_d = master_next;
        else if (hit) state_d = P_REQ;
      end
      P_REQ:    if (got) state_d = P_LOAD;
      P_LOAD:   state_d = P_SETTLE;
      P_SETTLE: if (done) state_d = PLAYER_TURN;
      M_REQ:    if (got) state_d = M_LOAD;
      M_LOAD:   state_d = M_SETTLE;
      M_SETTLE: if (done) state_d = master_next;
      COMPARE: begin
        result_d = judge(totalValuePlayer, totalValueMaster);
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge new_Game_n) begin
    if (!new_Game_n) begin
      state_q  <= IDLE;
      p_cnt_q  <= '0;
      m_cnt_q  <= '0;
      tgt_q    <= 1'b0;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      p_cnt_q  <= p_cnt_d;
      m_cnt_q  <= m_cnt_d;
      tgt_q    <= tgt_d;
      result_q <= result_d;
    end
  end

  assign round_clear  = (state_q == CLEAR);
  assign busy         = !(state_q inside {IDLE, DONE});
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule
